// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per clock; signed operands are divided as magnitudes and
// the signs are applied when the result is formed. Divide-by-zero returns 0.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    // Two's complement negation.
    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] x);
        return ~x + DATA_W'(1);
    endfunction

    // Magnitude of an operand when it is to be treated as signed.
    function automatic logic [DATA_W-1:0] mag_w(input logic [DATA_W-1:0] x,
                                                input logic              is_signed);
        return (is_signed && x[DATA_W-1]) ? neg_w(x) : x;
    endfunction

    logic [1:0]          state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2*DATA_W:0]   dividend_r;   // {partial remainder, quotient bits}
    logic [DATA_W-1:0]   divisor_r;
    logic                signed_r;
    logic                sign1_r;
    logic                sign2_r;

    logic                fits_s;
    logic [DATA_W:0]     diff_s;
    logic [2*DATA_W:0]   step_next_s;
    logic [DATA_W-1:0]   quo_mag_s;
    logic [DATA_W-1:0]   rem_mag_s;
    logic [DATA_W-1:0]   quo_s;
    logic [DATA_W-1:0]   rem_s;
    logic [DATA_W-1:0]   op1_mag_s;
    logic [DATA_W-1:0]   op2_mag_s;

    // Operand magnitudes for latching on the start edge.
    always_comb begin
        op1_mag_s = mag_w(opdata1_i, signed_div_i);
        op2_mag_s = mag_w(opdata2_i, signed_div_i);
    end

    // One restoring step: shift left, trial-subtract the divisor from the upper field.
    // dividend_r[2W:W-1] is the upper field after the shift; the compare sees its full
    // width, while the kept difference always fits in W+1 bits when the subtraction succeeds.
    always_comb begin
        fits_s = (dividend_r[2*DATA_W:DATA_W-1] >= {2'b00, divisor_r});
        diff_s = dividend_r[2*DATA_W-1:DATA_W-1] - {1'b0, divisor_r};
        if (fits_s) begin
            step_next_s = {diff_s, dividend_r[DATA_W-2:0], 1'b1};
        end else begin
            step_next_s = {dividend_r[2*DATA_W-1:0], 1'b0};
        end
    end

    // Result formation: the remainder is bits [2W:W+1] of the register shifted once
    // more, i.e. bits [2W-1:W] as stored; signs are re-applied for DIV.
    always_comb begin
        quo_mag_s = dividend_r[DATA_W-1:0];
        rem_mag_s = dividend_r[2*DATA_W-1:DATA_W];
        if (signed_r && (sign1_r != sign2_r)) begin
            quo_s = neg_w(quo_mag_s);
        end else begin
            quo_s = quo_mag_s;
        end
        if (signed_r && sign1_r) begin
            rem_s = neg_w(rem_mag_s);
        end else begin
            rem_s = rem_mag_s;
        end
    end

    // Divider control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= DIV_FREE;
            cnt_r      <= '0;
            ready_o    <= 1'b0;
            result_o   <= '0;
            dividend_r <= '0;
            divisor_r  <= '0;
            signed_r   <= 1'b0;
            sign1_r    <= 1'b0;
            sign2_r    <= 1'b0;
        end else begin
            case (state_r)
                DIV_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        signed_r   <= signed_div_i;
                        sign1_r    <= signed_div_i & opdata1_i[DATA_W-1];
                        sign2_r    <= signed_div_i & opdata2_i[DATA_W-1];
                        divisor_r  <= op2_mag_s;
                        dividend_r <= {{(DATA_W+1){1'b0}}, op1_mag_s};
                        cnt_r      <= '0;
                        if (opdata2_i == '0) begin
                            state_r <= DIV_BY_ZERO;
                        end else begin
                            state_r <= DIV_ON;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (annul_i) begin
                        state_r <= DIV_FREE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        state_r  <= DIV_END;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state_r <= DIV_FREE;
                    end else if (cnt_r != LAST_CNT) begin
                        dividend_r <= step_next_s;
                        cnt_r      <= cnt_r + CNT_W'(1);
                    end else begin
                        result_o <= {rem_s, quo_s};
                        ready_o  <= 1'b1;
                        state_r  <= DIV_END;
                    end
                end
                DIV_END: begin
                    // Flush is signalled by EX dropping start_i, so annul_i is not looked at here.
                    if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        state_r  <= DIV_FREE;
                    end
                end
                default: begin
                    state_r  <= DIV_FREE;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors with literal expectations,
// plus a transaction-level model compared against the outputs every cycle.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: truncating division in 64-bit signed arithmetic.
    function automatic logic [63:0] model_ans(input bit sgn, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Transaction model: accept, wait the fixed latency, present, hold until start drops.
    bit          m_busy   = 1'b0;
    int          m_left   = 0;
    logic [63:0] m_ans    = 64'd0;
    bit          m_ready  = 1'b0;
    logic [63:0] m_result = 64'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_left   <= 0;
            m_ready  <= 1'b0;
            m_result <= 64'd0;
        end else if (m_ready) begin
            if (!start) begin
                m_ready  <= 1'b0;
                m_result <= 64'd0;
            end
        end else if (m_busy) begin
            if (annul) begin
                m_busy <= 1'b0;
            end else if (m_left == 1) begin
                m_busy   <= 1'b0;
                m_ready  <= 1'b1;
                m_result <= m_ans;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (start && !annul) begin
            m_busy <= 1'b1;
            m_left <= (op2 == 32'd0) ? 1 : 33;
            m_ans  <= model_ans(signed_div, op1, op2);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (ready !== m_ready || result !== m_result) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t ready got %0b want %0b result got %h want %h",
                         $time, ready, m_ready, result, m_result);
            end
        end
    end

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic run_div(input string name, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
        int n;
        @(negedge clk);
        signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk);
        // Operands are only sampled on the start edge; scramble them afterwards.
        @(negedge clk);
        op1 = $urandom; op2 = $urandom; signed_div = ~sgn;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ready) break;
        end
        checks++;
        if (ready !== 1'b1 || n != exp_lat) begin
            failures++;
            $display("FAIL %s_latency got %0d (ready=%0b) want %0d", name, n, ready, exp_lat);
        end
        check64({name, "_result"}, result, exp_res);
        repeat (3) @(posedge clk);
        #1;
        check64({name, "_hold"}, {ready, result[62:0]}, {1'b1, exp_res[62:0]});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check64({name, "_release"}, {63'd0, ready} | result, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        bit saw_ready;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = 32'd0; op2 = 32'd0;

        // Pin the reference model to hand-computed values.
        check64("model_u100_7", model_ans(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        check64("model_sm7_2", model_ans(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        check64("model_s7_m2", model_ans(1'b1, 32'd7, 32'hFFFFFFFE), 64'h00000001_FFFFFFFD);
        check64("model_min_m1", model_ans(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

        repeat (3) @(posedge clk);
        #1;
        check64("reset_state", {63'd0, ready} | result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        run_div("u100_7",     1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 33);
        run_div("s_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("s_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
        run_div("s_min_m1",   1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        run_div("u_max_1",    1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33);
        run_div("u_5_9",      1'b0, 32'd5,        32'd9,        64'h00000005_00000000, 33);
        run_div("u_min_max",  1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33);
        run_div("s_m100_m7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33);
        run_div("u_div0",     1'b0, 32'd1234,     32'd0,        64'd0, 1);
        run_div("s_div0",     1'b1, 32'hFFFFFF9C, 32'd0,        64'd0, 1);

        // Annul at cnt=10: no result is ever presented.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        saw_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready) saw_ready = 1'b1;
        end
        checks++;
        if (saw_ready) begin
            failures++;
            $display("FAIL annul_no_ready got ready=1 want ready=0");
        end
        run_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        // Reset at cnt=20, then a fresh division.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check64("mid_reset", {63'd0, ready} | result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("after_rst", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
